// File: rtl/dump_sequencer.sv
// -----------------------------------------------------------------------------
// dump_sequencer
//
// Debug-side scheduler that serialises processor state to a UART transmitter
// after a halt or single step. Dump order: PC, every register-file entry,
// then MEM_WORDS words of data memory starting at byte address 0. Each word
// is sent MSB byte first using a start/done handshake with the UART TX.
//
// Optional feature (compile-time macro DUMP_CHECKSUM_EN):
//   When defined, a running XOR of every transmitted byte is appended as one
//   extra byte after the last memory word, and o_done follows that byte.
//   When undefined, no checksum logic exists.
//
// Ports:
//   i_clock     system clock
//   i_reset     synchronous, active-high reset (aborts a dump in progress)
//   i_dump_req  single-cycle dump request (ignored while busy)
//   i_pc        PC debug value
//   i_reg       register-file debug read data (1-cycle read latency)
//   i_mem       data-memory debug read data (1-cycle read latency)
//   i_tx_done   UART TX finished the current byte (one-cycle pulse)
//   o_reg_addr  register index being read
//   o_reg_send  register debug read strobe
//   o_mem_addr  data-memory byte address being read (word index * 4)
//   o_mem_send  data-memory debug read strobe
//   o_tx_byte   byte to transmit
//   o_tx_start  one-cycle pulse launching o_tx_byte
//   o_busy      dump in progress
//   o_done      one-cycle pulse after the final byte completed
// -----------------------------------------------------------------------------
module dump_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGS        = 32,
  parameter int MEM_WORDS       = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH_UART = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_dump_req,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  input  logic [DATA_WIDTH-1:0]      i_reg,
  input  logic [DATA_WIDTH-1:0]      i_mem,
  input  logic                       i_tx_done,
  output logic [REG_ADDR_WIDTH-1:0]  o_reg_addr,
  output logic                       o_reg_send,
  output logic [DATA_WIDTH-1:0]      o_mem_addr,
  output logic                       o_mem_send,
  output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
  output logic                       o_tx_start,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int BYTES  = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int BCNT_W = $clog2(BYTES + 1);
  localparam int MAX_W  = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
  // One extra bit of headroom so a count equal to 2^REG_ADDR_WIDTH never wraps.
  localparam int IDX_W  = $clog2(MAX_W + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_CAPT,
    S_SEND,
    S_WAIT,
    S_NEXT,
`ifdef DUMP_CHECKSUM_EN
    S_CSUM,
    S_CSUM_WAIT,
`endif
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC,
    SEC_REG,
    SEC_MEM
  } section_t;

  state_t                state, state_next;
  section_t              section;
  logic [IDX_W-1:0]      index;
  logic [BCNT_W-1:0]     byte_cnt;
  logic [DATA_WIDTH-1:0] shift_word;

  logic last_reg;
  logic last_mem;
  logic last_byte;

  assign last_reg  = (index == IDX_W'(NUM_REGS - 1));
  assign last_mem  = (index == IDX_W'(MEM_WORDS - 1));
  assign last_byte = (byte_cnt == BCNT_W'(BYTES - 1));

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH_UART-1:0] csum;
`endif

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (i_dump_req) state_next = S_SEL;
      S_SEL:    state_next = S_CAPT;
      S_CAPT:   state_next = S_SEND;
      S_SEND:   state_next = S_WAIT;
      S_WAIT: begin
        if (i_tx_done) state_next = last_byte ? S_NEXT : S_SEND;
      end
      S_NEXT: begin
        if (section == SEC_MEM && last_mem) begin
`ifdef DUMP_CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_FINISH;
`endif
        end else begin
          state_next = S_SEL;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM:      state_next = S_CSUM_WAIT;
      S_CSUM_WAIT: if (i_tx_done) state_next = S_FINISH;
`endif
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded purely from state so every output is 0 in IDLE.
  always_comb begin
    o_reg_addr = '0;
    o_reg_send = 1'b0;
    o_mem_addr = '0;
    o_mem_send = 1'b0;
    o_tx_byte  = '0;
    o_tx_start = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      S_SEL, S_CAPT: begin
        // Address and strobe held through CAPT to cover the read latency.
        o_busy = 1'b1;
        if (section == SEC_REG) begin
          o_reg_addr = REG_ADDR_WIDTH'(index);
          o_reg_send = 1'b1;
        end else if (section == SEC_MEM) begin
          o_mem_addr = DATA_WIDTH'(index) << 2;
          o_mem_send = 1'b1;
        end
      end
      S_SEND: begin
        o_busy     = 1'b1;
        o_tx_byte  = shift_word[DATA_WIDTH-1 -: DATA_WIDTH_UART];
        o_tx_start = 1'b1;
      end
      S_WAIT: begin
        o_busy    = 1'b1;
        o_tx_byte = shift_word[DATA_WIDTH-1 -: DATA_WIDTH_UART];
      end
      S_NEXT: o_busy = 1'b1;
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        o_busy     = 1'b1;
        o_tx_byte  = csum;
        o_tx_start = 1'b1;
      end
      S_CSUM_WAIT: begin
        o_busy    = 1'b1;
        o_tx_byte = csum;
      end
`endif
      S_FINISH: o_done = 1'b1;
      default: ;
    endcase
  end

  // Section / word index / byte counter
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      section  <= SEC_PC;
      index    <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_dump_req) begin
            section <= SEC_PC;
            index   <= '0;
          end
        end
        S_CAPT: byte_cnt <= '0;
        S_WAIT: if (i_tx_done) byte_cnt <= byte_cnt + BCNT_W'(1);
        S_NEXT: begin
          if (section == SEC_PC) begin
            section <= SEC_REG;
            index   <= '0;
          end else if (section == SEC_REG && last_reg) begin
            section <= SEC_MEM;
            index   <= '0;
          end else begin
            index <= index + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Shift word: data path only, never observed outside SEND/WAIT.
  always_ff @(posedge i_clock) begin
    if (state == S_CAPT) begin
      case (section)
        SEC_REG: shift_word <= i_reg;
        SEC_MEM: shift_word <= i_mem;
        default: shift_word <= i_pc;
      endcase
    end else if (state == S_WAIT && i_tx_done) begin
      shift_word <= shift_word << DATA_WIDTH_UART;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // Running XOR, accumulated as each data byte is launched.
  always_ff @(posedge i_clock) begin
    if (state == S_IDLE && i_dump_req) begin
      csum <= '0;
    end else if (state == S_SEND) begin
      csum <= csum ^ shift_word[DATA_WIDTH-1 -: DATA_WIDTH_UART];
    end
  end
`endif

endmodule

// File: tb/tb_dump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dump_sequencer
//
// Self-checking bench for dump_sequencer. A behavioural model builds the
// expected byte stream from the PC/register/memory contents; the bench also
// models 1-cycle-latency debug read ports and a UART TX that answers each
// start with a done pulse after a fixed or random delay.
// -----------------------------------------------------------------------------
module tb_dump_sequencer;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int MW  = 32;
  localparam int RAW = 5;
  localparam int UW  = 8;
  localparam int BPW = DW / 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif
  localparam int DATA_LEN   = (1 + NR + MW) * BPW;
  localparam int STREAM_LEN = DATA_LEN + CSUM_BYTES;
  localparam int BUDGET     = 6000;

  logic           clk;
  logic           i_reset;
  logic           i_dump_req;
  logic [DW-1:0]  i_pc;
  logic [DW-1:0]  i_reg;
  logic [DW-1:0]  i_mem;
  logic           i_tx_done;
  logic [RAW-1:0] o_reg_addr;
  logic           o_reg_send;
  logic [DW-1:0]  o_mem_addr;
  logic           o_mem_send;
  logic [UW-1:0]  o_tx_byte;
  logic           o_tx_start;
  logic           o_busy;
  logic           o_done;

  dump_sequencer #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .MEM_WORDS(MW),
    .REG_ADDR_WIDTH(RAW), .DATA_WIDTH_UART(UW)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_dump_req(i_dump_req),
    .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem), .i_tx_done(i_tx_done),
    .o_reg_addr(o_reg_addr), .o_reg_send(o_reg_send),
    .o_mem_addr(o_mem_addr), .o_mem_send(o_mem_send),
    .o_tx_byte(o_tx_byte), .o_tx_start(o_tx_start),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] regs [NR];
  logic [DW-1:0] mem  [MW];
  logic [7:0]    exp_q[$];

  function automatic void push_word(input logic [DW-1:0] w);
    for (int b = BPW - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endfunction

  function automatic void build_expected();
    logic [7:0] x;
    exp_q.delete();
    push_word(i_pc);
    for (int k = 0; k < NR; k++) push_word(regs[k]);
    for (int k = 0; k < MW; k++) push_word(mem[k]);
    if (CSUM_BYTES != 0) begin
      x = 8'h00;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(x);
    end
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({o_reg_addr, o_reg_send, o_mem_addr, o_mem_send,
                o_tx_byte, o_tx_start, o_busy, o_done});
  endfunction

  // ---------------- environment / monitor ----------------
  int            fixed_delay = 5;   // 0 selects a random delay of 1..6 cycles
  int            tx_wait = 0;
  logic [7:0]    byte_q[$];
  int            done_seen, txdone_total, txdone_at_done;
  int            overlap_err, busy_done_err, run_addr_err;
  logic          prev_reg_send, prev_mem_send;
  logic [RAW-1:0] prev_reg_addr;
  logic [DW-1:0] prev_mem_addr;
  int            reg_run, mem_run;
  logic [DW-1:0] reg_run_addr, mem_run_addr;
  int            reg_runs_addr[$], reg_runs_len[$];
  int            mem_runs_addr[$], mem_runs_len[$];

  always @(negedge clk) begin
    int idx;
    // Read ports: data for the address presented one cycle earlier, garbage otherwise.
    i_reg = prev_reg_send ? regs[prev_reg_addr] : $urandom;
    idx = int'(prev_mem_addr >> 2);
    i_mem = (prev_mem_send && idx < MW) ? mem[idx] : $urandom;
    prev_reg_send = o_reg_send;
    prev_reg_addr = o_reg_addr;
    prev_mem_send = o_mem_send;
    prev_mem_addr = o_mem_addr;

    // UART TX model
    if (i_reset) begin
      tx_wait   = 0;
      i_tx_done = 1'b0;
    end else begin
      i_tx_done = 1'b0;
      if (tx_wait > 0) begin
        tx_wait--;
        if (tx_wait == 0) begin
          i_tx_done = 1'b1;
          txdone_total++;
        end
      end
      if (o_tx_start) begin
        byte_q.push_back(o_tx_byte);
        tx_wait = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 6));
      end
    end

    if (o_done) begin
      done_seen++;
      txdone_at_done = txdone_total;
      if (o_busy) busy_done_err++;
    end
    if (o_reg_send && o_mem_send) overlap_err++;

    if (o_reg_send) begin
      if (reg_run == 0) reg_run_addr = DW'(o_reg_addr);
      else if (DW'(o_reg_addr) != reg_run_addr) run_addr_err++;
      reg_run++;
    end else if (reg_run > 0) begin
      reg_runs_addr.push_back(int'(reg_run_addr));
      reg_runs_len.push_back(reg_run);
      reg_run = 0;
    end
    if (o_mem_send) begin
      if (mem_run == 0) mem_run_addr = o_mem_addr;
      else if (o_mem_addr != mem_run_addr) run_addr_err++;
      mem_run++;
    end else if (mem_run > 0) begin
      mem_runs_addr.push_back(int'(mem_run_addr));
      mem_runs_len.push_back(mem_run);
      mem_run = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    byte_q.delete();
    reg_runs_addr.delete(); reg_runs_len.delete();
    mem_runs_addr.delete(); mem_runs_len.delete();
    done_seen = 0; txdone_total = 0; txdone_at_done = 0;
    overlap_err = 0; busy_done_err = 0; run_addr_err = 0;
    reg_run = 0; mem_run = 0;
  endtask

  task automatic randomize_state();
    i_pc = $urandom;
    for (int k = 0; k < NR; k++) regs[k] = $urandom;
    for (int k = 0; k < MW; k++) mem[k] = $urandom;
  endtask

  task automatic pulse_req();
    i_dump_req = 1'b1;
    tick();
    i_dump_req = 1'b0;
  endtask

  // Run one full dump and compare everything against the model.
  task automatic do_dump(input string name, input int mid_req_cycle);
    int cyc;
    int bad;
    build_expected();
    clear_monitor();
    pulse_req();
    tick();
    check_eq({name, "/busy_rise"}, 64'(o_busy), 64'd1);
    cyc = 0;
    while (done_seen == 0 && cyc < BUDGET) begin
      if (cyc == mid_req_cycle) pulse_req();
      else tick();
      cyc++;
    end
    check_eq({name, "/done_in_budget"}, 64'(done_seen != 0), 64'd1);
    for (int i = 0; i < 8; i++) tick();
    check_eq({name, "/busy_after"}, 64'(o_busy), 64'd0);
    check_eq({name, "/done_count"}, 64'(done_seen), 64'd1);
    check_eq({name, "/busy_during_done"}, 64'(busy_done_err), 64'd0);
    check_eq({name, "/done_after_last_txdone"}, 64'(txdone_at_done), 64'(STREAM_LEN));
    check_eq({name, "/byte_count"}, 64'(byte_q.size()), 64'(STREAM_LEN));
    bad = 0;
    for (int i = 0; i < STREAM_LEN; i++)
      if (i >= byte_q.size() || byte_q[i] !== exp_q[i]) bad++;
    check_eq({name, "/byte_mismatches"}, 64'(bad), 64'd0);
    check_eq({name, "/strobe_overlap"}, 64'(overlap_err), 64'd0);
    check_eq({name, "/addr_stable"}, 64'(run_addr_err), 64'd0);
    check_eq({name, "/reg_runs"}, 64'(reg_runs_addr.size()), 64'(NR));
    check_eq({name, "/mem_runs"}, 64'(mem_runs_addr.size()), 64'(MW));
    bad = 0;
    foreach (reg_runs_addr[i]) if (reg_runs_addr[i] != i || reg_runs_len[i] != 2) bad++;
    foreach (mem_runs_addr[i]) if (mem_runs_addr[i] != i * 4 || mem_runs_len[i] != 2) bad++;
    check_eq({name, "/strobe_sweep"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int zero_err;
    i_reset = 1'b1; i_dump_req = 1'b0; i_pc = '0;
    i_reg = '0; i_mem = '0; i_tx_done = 1'b0;
    prev_reg_send = 1'b0; prev_mem_send = 1'b0;
    prev_reg_addr = '0; prev_mem_addr = '0;
    clear_monitor();
    for (int i = 0; i < 3; i++) tick();
    check_eq("reset/outputs", out_vec(), 64'd0);
    i_reset = 1'b0;

    // Idle with no request: every output stays 0.
    zero_err = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_vec() !== 64'd0) zero_err++;
    end
    check_eq("idle/outputs_nonzero_cycles", 64'(zero_err), 64'd0);
    check_eq("idle/busy", 64'(o_busy), 64'd0);

    // Directed pattern, 5-cycle TX.
    fixed_delay = 5;
    i_pc = 32'h0000_0010;
    for (int k = 0; k < NR; k++) regs[k] = DW'(k);
    for (int k = 0; k < MW; k++) mem[k] = 32'hA000_0000 + DW'(k);
    do_dump("directed", -1);
    if (byte_q.size() >= DATA_LEN) begin
      check_eq("directed/byte3", 64'(byte_q[3]), 64'h10);
      check_eq("directed/byte7", 64'(byte_q[7]), 64'h00);
      check_eq("directed/byte11", 64'(byte_q[11]), 64'h01);
      check_eq("directed/lastword", 64'({byte_q[DATA_LEN-4], byte_q[DATA_LEN-3],
                                         byte_q[DATA_LEN-2], byte_q[DATA_LEN-1]}),
               64'hA000_001F);
    end else begin
      check_eq("directed/stream_short", 64'(byte_q.size()), 64'(DATA_LEN));
    end

    // Random contents, random TX delay, extra request mid-dump.
    fixed_delay = 0;
    randomize_state();
    do_dump("random_midreq", 500);

    // Reset while waiting on byte 40.
    fixed_delay = 5;
    randomize_state();
    clear_monitor();
    pulse_req();
    begin
      int cyc;
      cyc = 0;
      while (byte_q.size() < 41 && cyc < BUDGET) begin
        tick();
        cyc++;
      end
    end
    check_eq("rst_mid/reached_byte40", 64'(byte_q.size()), 64'd41);
    tick();                        // now in WAIT for byte 40
    i_reset = 1'b1;
    tick();
    check_eq("rst_mid/outputs", out_vec(), 64'd0);
    i_reset = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check_eq("rst_mid/no_done", 64'(done_seen), 64'd0);
    check_eq("rst_mid/no_more_bytes", 64'(byte_q.size()), 64'd41);
    randomize_state();
    do_dump("after_reset", -1);

    // More random dumps.
    for (int r = 0; r < 2; r++) begin
      fixed_delay = 0;
      randomize_state();
      do_dump($sformatf("random%0d", r), -1);
    end

`ifdef DUMP_CHECKSUM_EN
    fixed_delay = 5;
    i_pc = 32'h0102_0304;
    for (int k = 0; k < NR; k++) regs[k] = '0;
    for (int k = 0; k < MW; k++) mem[k] = '0;
    do_dump("checksum", -1);
    if (byte_q.size() == STREAM_LEN)
      check_eq("checksum/last_byte", 64'(byte_q[STREAM_LEN-1]), 64'h04);
    else
      check_eq("checksum/stream_len", 64'(byte_q.size()), 64'(STREAM_LEN));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dump_sequencer.md
Name: dump_sequencer

Overview:
- Debug-side scheduler that serialises the processor state to the UART transmitter after a halt or a step.
- Dump order: the PC, then every register-file entry, then a window of data memory.
- Drives the register-file and data-memory debug read ports (address plus send strobe) one word at a time.
- Splits each word into bytes and hands them to the UART TX with a start/done handshake.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- NUM_REGS, 32, number of register-file entries dumped.
- MEM_WORDS, 32, number of data-memory words dumped, starting at byte address 0.
- REG_ADDR_WIDTH, 5, register index width; must satisfy 2^REG_ADDR_WIDTH >= NUM_REGS.
- DATA_WIDTH_UART, 8, UART byte width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_dump_req  in  1  single-cycle request to start a dump (halt reached or step done).
- i_pc  in  DATA_WIDTH  current PC debug value.
- i_reg  in  DATA_WIDTH  register-file debug read data.
- i_mem  in  DATA_WIDTH  data-memory debug read data.
- i_tx_done  in  1  UART TX finished the current byte (one-cycle pulse).
- o_reg_addr  out  REG_ADDR_WIDTH  register index being read.
- o_reg_send  out  1  register debug read strobe.
- o_mem_addr  out  DATA_WIDTH  data-memory byte address being read (word index * 4).
- o_mem_send  out  1  data-memory debug read strobe.
- o_tx_byte  out  DATA_WIDTH_UART  byte to transmit.
- o_tx_start  out  1  one-cycle pulse that launches o_tx_byte.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle pulse when the final byte has completed.

Behaviour:
- Reset values: all outputs 0; state IDLE; word and byte counters 0.
- Clock and reset: one clock (i_clock); reset is synchronous and active-high (i_reset).
- Reset mid-dump: aborts immediately. The next cycle is IDLE with all outputs 0, and no o_done is issued.
- States: IDLE, SEL, CAPT, SEND, WAIT, NEXT, FINISH.
- IDLE:
  - On i_dump_req go to SEL; o_busy rises on the next cycle.
  - Section is PC, word index 0.
- SEL:
  - REG section: drive o_reg_addr = index and o_reg_send = 1.
  - MEM section: drive o_mem_addr = index << 2 and o_mem_send = 1.
  - PC section: no strobe.
  - Always go to CAPT. Read latency is 1 cycle, so address and strobe are held through CAPT.
- CAPT:
  - Latch i_pc, i_reg or i_mem into the shift word according to section.
  - Deassert strobes; byte counter = 0; go to SEND.
- SEND:
  - o_tx_byte = shift word[DATA_WIDTH-1 -: 8] (MSB first).
  - o_tx_start = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - Hold o_tx_byte until i_tx_done.
  - On i_tx_done: shift word left by 8 and increment the byte counter.
  - If the byte counter has not reached DATA_WIDTH/8 - 1, go to SEND; otherwise go to NEXT.
  - An i_tx_done arriving in the same cycle as o_tx_start is not expected and is ignored (WAIT is entered one cycle later).
- NEXT, section advance:
  - PC goes to REG index 0.
  - REG index NUM_REGS-1 goes to MEM index 0.
  - MEM index MEM_WORDS-1 goes to FINISH.
  - Otherwise index+1, back to SEL.
- FINISH:
  - o_done = 1 for one cycle; o_busy drops in the same cycle; return to IDLE.
- i_dump_req while o_busy or in FINISH: ignored, not queued.
- Stream length: (1 + NUM_REGS + MEM_WORDS) * DATA_WIDTH/8 bytes, which is 260 bytes with defaults.
- Counters are sized so that NUM_REGS or MEM_WORDS up to 2^REG_ADDR_WIDTH do not wrap early.
- Per-word overhead is 3 cycles (SEL, CAPT, NEXT) plus per-byte TX time.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of every transmitted byte is kept, cleared on leaving IDLE.
  - After the last MEM word, a state CSUM sends the checksum byte with the same start/done handshake.
  - o_done follows that byte's i_tx_done; stream is 261 bytes with defaults.
- Undefined: no checksum logic, no CSUM state, stream is 260 bytes.

Test Plan:
- Reset then idle, no request -> all outputs 0 for 100 cycles; o_busy = 0.
- i_pc = 0x00000010, regs[k] = k, mem[k] = 0xA0000000 + k, TX model returns i_tx_done 5 cycles after each o_tx_start, pulse i_dump_req -> byte stream begins 00 00 00 10 00 00 00 00 00 00 00 01 ...; 260 o_tx_start pulses; last bytes A0 00 00 1F; single o_done; o_busy low afterwards.
- Read-port check -> o_reg_addr sweeps 0..31 with o_reg_send high exactly 2 cycles per word; o_mem_addr sweeps 0, 4, ..., 124 with o_mem_send likewise; strobes never overlap.
- Second i_dump_req pulsed mid-dump -> ignored; byte count stays 260; exactly one o_done.
- i_reset asserted while in WAIT on byte 40 -> next cycle IDLE, outputs 0, no o_done; a new request restarts from PC byte 0.
- With DUMP_CHECKSUM_EN, all regs and mem = 0, i_pc = 0x01020304 -> byte 261 = 0x04 (01^02^03^04); o_done after its i_tx_done.
